// File: rtl/uart_pkg.sv
// uart_pkg: shared UART TX-path types and default widths.
package uart_pkg;

   localparam int UART_DATA_WIDTH = 8;
   localparam int UART_GAP_WIDTH  = 8;
   localparam int UART_CNT_WIDTH  = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_ACK,
      WAIT_DONE,
      GAP
   } sched_state_e;

endpackage

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: pops the TX FIFO, launches serializer frames, enforces idle gap.
// Define UART_CTS_EN to add the active-low clear-to-send input gating launches.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int GAP_WIDTH  = UART_GAP_WIDTH,
   parameter int CNT_WIDTH  = UART_CNT_WIDTH
) (
   input  logic                  sched_clk_i,
   input  logic                  sched_rst_n_i,
   input  logic                  sched_en_i,
   input  logic [GAP_WIDTH-1:0]  sched_gap_i,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_data_i,
   output logic                  fifo_rd_en_o,
   output logic [DATA_WIDTH-1:0] tx_data_o,
   output logic                  tx_start_o,
   input  logic                  tx_busy_i,
`ifdef UART_CTS_EN
   input  logic                  sched_cts_n_i,
`endif
   output logic                  sched_busy_o,
   output logic [CNT_WIDTH-1:0]  sched_frame_cnt_o
);

   localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   sched_state_e          state_q, state_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  tx_start_q, tx_start_d;
   logic                  rd_en_q, rd_en_d;
   logic                  busy_q, busy_d;
   logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
   logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
   logic                  launch;

   always_comb begin
      launch = sched_en_i & ~fifo_empty_i;
`ifdef UART_CTS_EN
      launch = launch & ~sched_cts_n_i;
`endif
   end

   // Start and pop are only ever raised on the IDLE->LOAD edge.
   always_comb begin
      state_d     = state_q;
      tx_data_d   = tx_data_q;
      tx_start_d  = 1'b0;
      rd_en_d     = 1'b0;
      gap_cnt_d   = gap_cnt_q;
      frame_cnt_d = frame_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (launch) begin
               state_d     = LOAD;
               tx_data_d   = fifo_data_i;
               tx_start_d  = 1'b1;
               rd_en_d     = 1'b1;
               frame_cnt_d = frame_cnt_q + CNT_ONE;
            end
         end
         LOAD: begin
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (tx_busy_i) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy_i) begin
               if (sched_gap_i == '0) begin
                  state_d = IDLE;
               end else begin
                  state_d   = GAP;
                  gap_cnt_d = sched_gap_i;
               end
            end
         end
         GAP: begin
            gap_cnt_d = gap_cnt_q - GAP_ONE;
            if (gap_cnt_q == GAP_ONE) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge sched_clk_i or negedge sched_rst_n_i) begin
      if (!sched_rst_n_i) begin
         state_q     <= IDLE;
         tx_data_q   <= '0;
         tx_start_q  <= 1'b0;
         rd_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         gap_cnt_q   <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         rd_en_q     <= rd_en_d;
         busy_q      <= busy_d;
         gap_cnt_q   <= gap_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign fifo_rd_en_o      = rd_en_q;
   assign tx_data_o         = tx_data_q;
   assign tx_start_o        = tx_start_q;
   assign sched_busy_o      = busy_q;
   assign sched_frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed table-driven bench for uart_tx_sched with
// FIFO and serializer models; CTS test is built when UART_CTS_EN is defined.
module tb_uart_tx_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [7:0] gap = 8'd0;
   logic       cts_n = 1'b0;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       rd_en, tx_start, tx_busy, sbusy;
   logic [7:0] tx_data;
   logic [15:0] cnt;

   logic       en2 = 1'b0;
   logic       empty2 = 1'b1;
   logic [7:0] data2 = 8'h5A;
   logic       rd2, st2, busy2, sb2;
   logic [7:0] txd2;
   logic [3:0] cnt2;

   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   uart_tx_sched dut (
      .sched_clk_i       (clk),
      .sched_rst_n_i     (rst_n),
      .sched_en_i        (en),
      .sched_gap_i       (gap),
      .fifo_empty_i      (fifo_empty),
      .fifo_data_i       (fifo_data),
      .fifo_rd_en_o      (rd_en),
      .tx_data_o         (tx_data),
      .tx_start_o        (tx_start),
      .tx_busy_i         (tx_busy),
`ifdef UART_CTS_EN
      .sched_cts_n_i     (cts_n),
`endif
      .sched_busy_o      (sbusy),
      .sched_frame_cnt_o (cnt)
   );

   uart_tx_sched #(.CNT_WIDTH(4)) dut_w (
      .sched_clk_i       (clk),
      .sched_rst_n_i     (rst_n),
      .sched_en_i        (en2),
      .sched_gap_i       (8'd0),
      .fifo_empty_i      (empty2),
      .fifo_data_i       (data2),
      .fifo_rd_en_o      (rd2),
      .tx_data_o         (txd2),
      .tx_start_o        (st2),
      .tx_busy_i         (busy2),
`ifdef UART_CTS_EN
      .sched_cts_n_i     (1'b0),
`endif
      .sched_busy_o      (sb2),
      .sched_frame_cnt_o (cnt2)
   );

   // FWFT FIFO model
   logic [7:0] mem [16];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int under_err = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_data  = mem[rd_ptr[3:0]];

   always @(posedge clk) begin
      if (rd_en) begin
         rd_ptr <= rd_ptr + 1;
         if (fifo_empty) under_err <= under_err + 1;
      end
   end

   // serializer models: busy from the cycle after start, for a fixed length
   int bcnt = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_busy <= 1'b0;
         bcnt    <= 0;
      end else if (tx_start) begin
         tx_busy <= 1'b1;
         bcnt    <= 10;
      end else if (bcnt > 1) begin
         bcnt <= bcnt - 1;
      end else if (bcnt == 1) begin
         bcnt    <= 0;
         tx_busy <= 1'b0;
      end
   end

   int bcnt2 = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy2 <= 1'b0;
         bcnt2 <= 0;
      end else if (st2) begin
         busy2 <= 1'b1;
         bcnt2 <= 3;
      end else if (bcnt2 > 1) begin
         bcnt2 <= bcnt2 - 1;
      end else if (bcnt2 == 1) begin
         bcnt2 <= 0;
         busy2 <= 1'b0;
      end
   end

   // monitor
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         st_cyc[$];
   logic [7:0] st_dat[$];
   int         fall_cyc[$];
   logic       busy_prev = 1'b0;
   int         coin_err = 0;
   int         rst_err = 0;
   int         s2cnt = 0;

   always @(negedge clk) begin
      if (tx_start) begin
         st_cyc.push_back(cyc);
         st_dat.push_back(tx_data);
      end
      if (tx_start != rd_en) coin_err <= coin_err + 1;
      if (st2 != rd2) coin_err <= coin_err + 1;
      if (!rst_n && (tx_start || rd_en || st2 || rd2)) rst_err <= rst_err + 1;
      if (busy_prev && !tx_busy) fall_cyc.push_back(cyc);
      if (st2) s2cnt <= s2cnt + 1;
      busy_prev <= tx_busy;
   end

   function automatic int stc(int i);
      return (i < st_cyc.size()) ? st_cyc[i] : -1000;
   endfunction

   function automatic int std(int i);
      return (i < st_dat.size()) ? int'(st_dat[i]) : -1;
   endfunction

   function automatic int flc(int i);
      return (i < fall_cyc.size()) ? fall_cyc[i] : -1000;
   endfunction

   task automatic check(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  nm, act, act, exp, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] v);
      mem[wr_ptr[3:0]] = v;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic do_reset();
      en = 1'b0;
      en2 = 1'b0;
      rst_n = 1'b0;
      tick(3);
      wr_ptr = rd_ptr;
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic wait_starts(input string nm, input int base, input int n,
                              input int budget);
      int k;
      k = 0;
      while (st_cyc.size() < base + n && k < budget) begin
         tick(1);
         k++;
      end
      check({nm, "_starts"}, st_cyc.size() - base, n);
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int k;
      k = 0;
      while (sbusy && k < budget) begin
         tick(1);
         k++;
      end
      check({nm, "_idle"}, sbusy, 0);
   endtask

   typedef struct {
      logic [7:0] g;
      logic [7:0] late;
      logic [7:0] w0;
      logic [7:0] w1;
      int         delta;
   } gap_vec_t;

   gap_vec_t vecs[5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, fb, c;
      vecs[0] = '{8'd5,   8'd5, 8'hA1, 8'hB2, 7};
      vecs[1] = '{8'd0,   8'd0, 8'h01, 8'h80, 2};
      vecs[2] = '{8'd1,   8'd1, 8'h55, 8'hAA, 3};
      vecs[3] = '{8'd5,   8'd0, 8'hC3, 8'h3C, 7};
      vecs[4] = '{8'd200, 8'd3, 8'h0F, 8'hF0, 202};

      // reset state
      tick(2);
      check("rst_start", tx_start, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_data", tx_data, 0);
      check("rst_busy", sbusy, 0);
      check("rst_cnt", cnt, 0);
      check("rst_cnt_w", cnt2, 0);
      rst_n = 1'b1;
      tick(2);

      // three-word drain
      do_reset();
      gap = 8'd0;
      push(8'hA5);
      push(8'h3C);
      push(8'hFF);
      b = st_cyc.size();
      en = 1'b1;
      wait_starts("drain", b, 3, 300);
      check("drain_d0", std(b), 8'hA5);
      check("drain_d1", std(b + 1), 8'h3C);
      check("drain_d2", std(b + 2), 8'hFF);
      wait_idle("drain", 100);
      tick(20);
      check("drain_cnt", cnt, 3);
      check("drain_empty", fifo_empty, 1);
      check("drain_no_extra", st_cyc.size() - b, 3);

      // gap accuracy table
      for (int i = 0; i < 5; i++) begin
         int k;
         do_reset();
         gap = vecs[i].g;
         push(vecs[i].w0);
         push(vecs[i].w1);
         b = st_cyc.size();
         fb = fall_cyc.size();
         en = 1'b1;
         k = 0;
         while (fall_cyc.size() <= fb && k < 100) begin
            tick(1);
            k++;
         end
         gap = vecs[i].late;
         wait_starts($sformatf("gap%0d", i), b, 2, 600);
         check($sformatf("gap%0d_d0", i), std(b), vecs[i].w0);
         check($sformatf("gap%0d_d1", i), std(b + 1), vecs[i].w1);
         check($sformatf("gap%0d_delta", i), stc(b + 1) - flc(fb),
               vecs[i].delta);
         check($sformatf("gap%0d_cnt", i), cnt, 2);
      end

      // enable drop during WAIT_DONE
      do_reset();
      gap = 8'd0;
      push(8'h10);
      push(8'h20);
      push(8'h30);
      b = st_cyc.size();
      fb = fall_cyc.size();
      en = 1'b1;
      wait_starts("endrop", b, 1, 50);
      tick(4);
      check("endrop_midbusy", sbusy, 1);
      en = 1'b0;
      tick(60);
      check("endrop_nostart", st_cyc.size() - b, 1);
      check("endrop_fifo", wr_ptr - rd_ptr, 2);
      check("endrop_done", fall_cyc.size() > fb, 1);
      check("endrop_idle", sbusy, 0);
      c = cyc;
      en = 1'b1;
      wait_starts("endrop_re", b, 2, 20);
      check("endrop_lat", stc(b + 1) - c, 1);
      check("endrop_d1", std(b + 1), 8'h20);
      en = 1'b0;
      wait_idle("endrop", 100);

      // reset during WAIT_ACK
      do_reset();
      push(8'h11);
      push(8'h22);
      b = st_cyc.size();
      en = 1'b1;
      wait_starts("midrst", b, 1, 50);
      rst_n = 1'b0;
      #1;
      check("midrst_data", tx_data, 0);
      check("midrst_cnt", cnt, 0);
      check("midrst_busy", sbusy, 0);
      check("midrst_start", tx_start, 0);
      check("midrst_rd", rd_en, 0);
      tick(4);
      check("midrst_quiet", st_cyc.size() - b, 1);
      rst_n = 1'b1;
      wait_starts("midrst_re", b, 2, 40);
      check("midrst_d", std(b + 1), 8'h22);
      tick(1);
      check("midrst_cnt1", cnt, 1);
      en = 1'b0;
      wait_idle("midrst", 100);

`ifdef UART_CTS_EN
      // clear-to-send gating
      do_reset();
      gap = 8'd0;
      cts_n = 1'b1;
      push(8'h77);
      b = st_cyc.size();
      fb = fall_cyc.size();
      en = 1'b1;
      tick(50);
      check("cts_block", st_cyc.size() - b, 0);
      c = cyc;
      cts_n = 1'b0;
      wait_starts("cts", b, 1, 10);
      check("cts_lat", stc(b) - c, 1);
      check("cts_d", std(b), 8'h77);
      tick(2);
      cts_n = 1'b1;
      wait_idle("cts", 100);
      check("cts_complete", fall_cyc.size() > fb, 1);
      cts_n = 1'b0;
      en = 1'b0;
`endif

      // frame counter wrap on the 4-bit instance
      do_reset();
      check("wrap_rst", cnt2, 0);
      begin
         int k;
         k = 0;
         empty2 = 1'b0;
         en2 = 1'b1;
         while (s2cnt < 17 && k < 400) begin
            tick(1);
            k++;
         end
         empty2 = 1'b1;
      end
      check("wrap_starts", s2cnt, 17);
      tick(20);
      check("wrap_cnt", cnt2, 1);
      check("wrap_no_extra", s2cnt, 17);
      check("wrap_idle", sb2, 0);
      en2 = 1'b0;

      check("coincident", coin_err, 0);
      check("no_pulse_in_rst", rst_err, 0);
      check("no_underflow", under_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
